// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the default NOP word and the PC stepping constants.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = '0;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read bus: the fetch unit drives a word-aligned Address
// and the memory returns Instruction combinationally for that address.
interface instruction_fetch_unit_if;

  logic [31:0] Address;
  logic [31:0] Instruction;

  modport master (output Address, input Instruction);
  modport slave  (input Address, output Instruction);

endinterface

// File: rtl/instruction_fetch_unit_ifid_pipe_reg.sv
// IF/ID pipeline register with load, hold and flush controls.
// Flush has priority over load; neither asserted means hold.
module ifid_pipe_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instruction_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // Register update: reset/flush insert a bubble, load captures the fetch.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      instruction <= NOP_WORD;
      pc_plus4    <= '0;
      valid       <= 1'b0;
    end else if (load) begin
      instruction <= instruction_in;
      pc_plus4    <= pc_plus4_in;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction-memory address
// and fills the IF/ID register; handles stall, branch/jump redirect and halt.
// Optional performance counters are built when IFETCH_PERF_EN is defined.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic                      Clk,
  input  logic                      Reset,
  instruction_fetch_unit_if.master  imem,
  input  logic                      Stall,
  input  logic                      BranchTaken,
  input  logic [31:0]               BranchTarget,
  input  logic                      JumpTaken,
  input  logic [31:0]               JumpTarget,
  input  logic                      Halt,
  output logic [31:0]               IfId_Instruction,
  output logic [31:0]               IfId_PCPlus4,
  output logic                      IfId_Valid,
  output logic                      Halted
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]               FetchCount,
  output logic [31:0]               StallCount,
  output logic [31:0]               FlushCount
`endif
);

  fetch_state_t state_q, next_state;
  logic [31:0]  pc_q, pc_d, pc_plus4;
  logic         ifid_load, ifid_flush, do_stall, do_redirect;

  assign pc_plus4     = pc_q + PC_INCR;
  assign imem.Address = pc_q;
  assign Halted       = (state_q == ST_HALTED);

  // State and PC register; PC is kept word-aligned at every load.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_START;
      pc_q    <= RESET_PC & PC_ALIGN_MASK;
    end else begin
      state_q <= next_state;
      pc_q    <= pc_d;
    end
  end

  // Next-state, next-PC and IF/ID control in priority order:
  // halt, branch, jump, stall, sequential fetch. START fetches like RUN.
  always_comb begin
    next_state  = state_q;
    pc_d        = pc_q;
    ifid_load   = 1'b0;
    ifid_flush  = 1'b0;
    do_stall    = 1'b0;
    do_redirect = 1'b0;
    case (state_q)
      ST_START, ST_RUN: begin
        next_state = ST_RUN;
        if (Halt) begin
          next_state = ST_HALTED;
          ifid_flush = 1'b1;
        end else if (BranchTaken) begin
          pc_d        = BranchTarget & PC_ALIGN_MASK;
          ifid_flush  = 1'b1;
          do_redirect = 1'b1;
        end else if (JumpTaken) begin
          pc_d        = JumpTarget & PC_ALIGN_MASK;
          ifid_flush  = 1'b1;
          do_redirect = 1'b1;
        end else if (Stall) begin
          do_stall = 1'b1;
        end else begin
          pc_d      = pc_plus4;
          ifid_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  ifid_pipe_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_ifid (
    .clk            (Clk),
    .rst_n          (Reset),
    .load           (ifid_load),
    .flush          (ifid_flush),
    .instruction_in (imem.Instruction),
    .pc_plus4_in    (pc_plus4),
    .instruction    (IfId_Instruction),
    .pc_plus4       (IfId_PCPlus4),
    .valid          (IfId_Valid)
  );

`ifdef IFETCH_PERF_EN
  // Event counters: fetch, stall and redirect-flush; frozen while halted.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      FetchCount <= '0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (ifid_load)   FetchCount <= FetchCount + 32'd1;
      if (do_stall)    StallCount <= StallCount + 32'd1;
      if (do_redirect) FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. Owns the program counter (PC), drives the word-aligned fetch address to the instruction memory, captures the returned instruction into the IF/ID pipeline register, and handles stall, redirect (branch/jump), flush and halt. Sits between the instruction memory and the decode stage of the pipelined MIPS datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush, halt and reset.

Ports:
Clk  input  1  system clock; all state updates on rising edge.
Reset  input  1  synchronous, active-low reset.
Address  output  32  fetch address to instruction memory; equals PC combinationally.
Instruction  input  32  instruction word returned combinationally by instruction memory for Address.
Stall  input  1  hazard unit request: hold PC and IF/ID.
BranchTaken  input  1  redirect from EX; highest-priority redirect.
BranchTarget  input  32  target for BranchTaken.
JumpTaken  input  1  redirect from ID.
JumpTarget  input  32  target for JumpTaken.
Halt  input  1  stop fetching permanently until reset.
IfId_Instruction  output  32  registered instruction to decode.
IfId_PCPlus4  output  32  registered PC+4 of that instruction.
IfId_Valid  output  1  1 = IF/ID holds a real fetched instruction.
Halted  output  1  1 while in HALTED state.

Behaviour:
- Reset (Reset==0 at rising edge): PC<=RESET_PC; IfId_Instruction<=NOP_WORD; IfId_PCPlus4<=0; IfId_Valid<=0; state<=START; Halted<=0. Overrides all other inputs.
- States: START (first cycle after reset), RUN, HALTED.
- START -> RUN unconditionally after one cycle; PC fetch occurs as in RUN (IF/ID loads instruction at RESET_PC). Halt in START -> HALTED.
- RUN, per edge, priority order:
  1. Halt: state->HALTED; PC held; IF/ID<=NOP_WORD, Valid<=0.
  2. BranchTaken: PC<={BranchTarget[31:2],2'b00}; IF/ID flushed (NOP_WORD, Valid=0). Overrides Stall and JumpTaken.
  3. JumpTaken: PC<={JumpTarget[31:2],2'b00}; IF/ID flushed. Overrides Stall.
  4. Stall: PC and all IF/ID outputs hold.
  5. Otherwise: PC<=PC+4 (32-bit modulo, 32'hFFFF_FFFC wraps to 0); IfId_Instruction<=Instruction; IfId_PCPlus4<=PC+4; Valid<=1.
- HALTED: PC, IF/ID hold NOP/Valid=0; all inputs except Reset ignored; Halted=1 (registered, asserted the cycle after Halt sampled).
- Address is PC with bits[1:0] always 0; memory indexes Address[8:2], so PC beyond 128 words aliases (no fault raised).
- Fetch latency: instruction at PC appears on IfId_Instruction one edge after PC is presented.
- Simultaneous BranchTaken and JumpTaken: branch wins (older instruction).
- Reset mid-stall or mid-redirect: reset wins; no partial update.

Optional Feature:
Macro IFETCH_PERF_EN. Defined: adds outputs FetchCount[31:0] (increments on every edge taking rule 5), StallCount[31:0] (increments on rule 4), FlushCount[31:0] (increments on rules 2 and 3); all clear on reset, wrap at 2^32, freeze in HALTED. Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared package/header: state encodings (ST_START, ST_RUN, ST_HALTED), NOP_WORD default, PC increment constant 4.
- One natural sub-module: ifid_pipe_reg (IF/ID register with load/hold/flush controls); PC logic and FSM stay in the top.

Test Plan:
- Reset, then 4 unstalled cycles with memory returning memory[i]=i*3 -> Address 0,4,8,12; IfId_Instruction 0,3,6 with IfId_PCPlus4 4,8,12; Valid=0 during first cycle then 1.
- Stall asserted 2 cycles at PC=8 -> Address stays 8, IF/ID holds word 3 / PCPlus4 8; resumes with word 6 after release.
- BranchTaken=1, BranchTarget=32'h40, with Stall=1 and JumpTaken=1 (JumpTarget=32'h80) same cycle -> next Address 32'h40, IfId_Instruction=NOP, Valid=0; next cycle IF/ID holds memory[16]=48.
- BranchTarget=32'h43 -> Address 32'h40 (low bits cleared).
- Halt at PC=12 -> Halted=1 next cycle, Address frozen at 12, Valid=0; toggling Stall/Branch has no effect; Reset=0 returns Address to RESET_PC.
- With IFETCH_PERF_EN: 5 fetches, 2 stalls, 1 jump -> FetchCount=5, StallCount=2, FlushCount=1; reset clears all to 0.
